calc: RTL and testbench

Score/combo/life bookkeeping block (module `calc`) for the memory game. The game controller issues one result event per answered round. This block keeps the running combo streak, the accumulated score (weighted by difficulty level and streak) and the remaining lives. Its outputs drive the display and the game-over logic.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/calc_sat_add.sv | 20 ++
 rtl/calc.sv | 61 ++++++
 tb/tb_calc.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared widths, saturation limits and level weighting for the score/combo/life block.
package calc_pkg;

    localparam int LIFE_INIT = 3;
    localparam int COMBO_MAX = 255;
    localparam int SCORE_MAX = 65535;

    typedef logic [7:0]  combo_t;
    typedef logic [15:0] score_t;
    typedef logic [1:0]  life_t;

    // Each level doubles the points earned per streak step.
    function automatic logic [3:0] level_base(input logic [1:0] level);
        case (level)
            2'd0:    level_base = 4'd1;
            2'd1:    level_base = 4'd2;
            2'd2:    level_base = 4'd4;
            default: level_base = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/calc_sat_add.sv
// Unsigned add of two W-bit values, clamped to MAX instead of wrapping.
module sat_add #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    localparam logic [W:0] MAX_V = (W+1)'(MAX);

    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        y   = (sum > MAX_V) ? MAX_V[W-1:0] : sum[W-1:0];
    end

endmodule

// File: rtl/calc.sv
// Round-result bookkeeping: combo streak, level-weighted score and remaining lives.
module calc #(
    parameter int LIFE_INIT = 3,
    parameter int COMBO_MAX = 255,
    parameter int SCORE_MAX = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        combo,
    input  logic [1:0]  level,
    input  logic        life,
    output logic [7:0]  o_combo,
    output logic [15:0] o_score,
    output logic [1:0]  o_life
);

    import calc_pkg::*;

    combo_t      combo_inc;
    score_t      score_sum;
    logic [10:0] term;
    logic        game_over;
    logic        act;

    assign game_over = (o_life == '0);
    assign act       = en && !game_over;

    sat_add #(.W(8), .MAX(COMBO_MAX)) u_combo_add (
        .a (o_combo),
        .b (8'd1),
        .y (combo_inc)
    );

    // Worst case 8 * 255 = 2040, so the 11-bit product never overflows.
    assign term = {7'd0, level_base(level)} * {3'd0, combo_inc};

    sat_add #(.W(16), .MAX(SCORE_MAX)) u_score_add (
        .a (o_score),
        .b ({5'd0, term}),
        .y (score_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            o_combo <= '0;
            o_score <= '0;
            o_life  <= life_t'(LIFE_INIT);
        end else if (act) begin
            if (combo) begin
                o_combo <= combo_inc;
                o_score <= score_sum;
            end else begin
                o_combo <= '0;
            end
            if (!life)
                o_life <= o_life - 2'd1;
        end
    end

endmodule

// File: tb/tb_calc.sv
// Self-checking bench for calc: directed test-plan steps plus a randomized phase, both
// compared every cycle against a plain-integer reference model.
module tb_calc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        combo = 1'b0;
    logic [1:0]  level = 2'd0;
    logic        life = 1'b1;
    logic [7:0]  o_combo;
    logic [15:0] o_score;
    logic [1:0]  o_life;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    int m_combo = 0;
    int m_score = 0;
    int m_life  = 3;

    calc dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .combo   (combo),
        .level   (level),
        .life    (life),
        .o_combo (o_combo),
        .o_score (o_score),
        .o_life  (o_life)
    );

    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: integer arithmetic straight from the game rules.
    always @(posedge clk) begin
        if (reset) begin
            m_combo <= 0;
            m_score <= 0;
            m_life  <= 3;
        end else if (en && m_life != 0) begin
            if (combo) begin
                m_combo <= imin(m_combo + 1, 255);
                m_score <= imin(m_score + (1 << level) * imin(m_combo + 1, 255), 65535);
            end else begin
                m_combo <= 0;
            end
            if (!life)
                m_life <= m_life - 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("model_combo", int'(o_combo), m_combo);
            check("model_score", int'(o_score), m_score);
            check("model_life",  int'(o_life),  m_life);
        end
    end

    task automatic step(input bit r, input bit e, input bit c, input int lv, input bit l);
        reset = r;
        en    = e;
        combo = c;
        level = 2'(lv);
        life  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string name, input int c, input int s, input int l);
        check({name, "_combo"}, int'(o_combo), c);
        check({name, "_score"}, int'(o_score), s);
        check({name, "_life"},  int'(o_life),  l);
    endtask

    initial begin
        // Reset wins over a simultaneous scoring event.
        step(1, 1, 1, 1, 1);
        armed = 1'b1;
        expect3("reset", 0, 0, 3);

        step(0, 1, 1, 1, 1);
        expect3("ev1", 1, 2, 3);
        step(0, 1, 1, 1, 1);
        expect3("ev2", 2, 6, 3);
        step(0, 1, 0, 2, 0);
        expect3("miss", 0, 6, 2);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 3, 0);
        expect3("idle", 0, 6, 2);

        step(1, 0, 0, 0, 1);
        step(0, 1, 1, 3, 1);
        expect3("lv3_1", 1, 8, 3);
        step(0, 1, 1, 3, 1);
        expect3("lv3_2", 2, 24, 3);
        step(0, 1, 1, 3, 1);
        expect3("lv3_3", 3, 48, 3);

        // 1+2+..+255 = 32640, then 45 more rounds at 255 each -> 44115.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) step(0, 1, 1, 0, 1);
        expect3("combo_sat", 255, 44115, 3);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 3, 1);
        expect3("score_sat", 255, 65535, 3);

        step(0, 1, 0, 0, 0);
        expect3("go1", 0, 65535, 2);
        step(0, 1, 1, 2, 0);
        expect3("go2", 1, 65535, 1);
        step(0, 1, 1, 2, 0);
        expect3("go3", 2, 65535, 0);
        step(0, 1, 1, 3, 0);
        expect3("frozen", 2, 65535, 0);
        step(1, 1, 1, 3, 1);
        expect3("rst_go", 0, 0, 3);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) != 0));
        end

        @(negedge clk);
        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
